// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler
//   Shares one single-port scratchpad SRAM among NUM_REQS load/store clients.
//   A rotating-priority pointer picks one requester per cycle and its beat is
//   presented to the SRAM in the same cycle. Read responses come back through
//   a fixed-latency tag pipeline that steers mem_rdata to the issuing client.
//
//   Build option: MEM_SCHED_BURST_LOCK_EN
//     defined   : a request with req_len>0 locks the grant until its last beat
//                 (addresses base+beat, wrapping at 2^ADDR_W).
//     undefined : req_len is ignored, every beat is arbitrated on its own and
//                 every response is flagged last.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        per-requester beat handshake (ready is one-hot)
//   req_we/req_addr/req_len    beat-0 command fields
//   req_wdata                  write data, taken on every accepted write beat
//   mem_en/mem_we/mem_addr/mem_wdata  SRAM command, sampled on next clk edge
//   mem_rdata                  SRAM read data, RD_LAT cycles after a read
//   rsp_valid/rsp_data/rsp_last one-hot read response, shared data bus
//   busy                       burst open or read responses still in flight
module mem_port_scheduler #(
  parameter int NUM_REQS = 4,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int BURST_W  = 3,
  parameter int RD_LAT   = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              req_valid,
  output logic [NUM_REQS-1:0]              req_ready,
  input  logic [NUM_REQS-1:0]              req_we,
  input  logic [NUM_REQS-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQS-1:0][BURST_W-1:0] req_len,
  input  logic [NUM_REQS-1:0][DATA_W-1:0]  req_wdata,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic [DATA_W-1:0]                mem_rdata,
  output logic [NUM_REQS-1:0]              rsp_valid,
  output logic [DATA_W-1:0]                rsp_data,
  output logic                             rsp_last,
  output logic                             busy
);
  localparam int ID_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  typedef logic [ID_W-1:0] id_t;
  typedef struct packed {
    logic vld;
    id_t  id;
    logic last;
  } rd_tag_t;

  id_t                ptr_q, ptr_d;
  rd_tag_t [RD_LAT:1] tag_q, tag_d;
  rd_tag_t            issue_tag;
  logic               found;
  id_t                win;

`ifdef MEM_SCHED_BURST_LOCK_EN
  typedef enum logic {S_IDLE, S_BURST} state_t;
  state_t             state_q, state_d;
  id_t                owner_q, owner_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic               we_q, we_d;
  logic [BURST_W-1:0] len_q, len_d, beat_q, beat_d;
`else
  logic unused_len;
  assign unused_len = ^req_len;
`endif

  function automatic id_t next_id(input id_t i);
    return (i == id_t'(NUM_REQS - 1)) ? '0 : id_t'(i + 1'b1);
  endfunction

  // Scan from the far end back towards ptr so the closest valid requester
  // is the last one written and therefore wins.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQS-1:0] v, input id_t p);
    logic [ID_W:0] r;
    int            idx;
    r = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      if (v[id_t'(idx)]) r = {1'b1, id_t'(idx)};
    end
    return r;
  endfunction

  always_comb begin
    req_ready = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    issue_tag = '0;
    ptr_d     = ptr_q;
    {found, win} = rr_pick(req_valid, ptr_q);
`ifdef MEM_SCHED_BURST_LOCK_EN
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    we_d    = we_q;
    len_d   = len_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          mem_en         = 1'b1;
          mem_we         = req_we[win];
          mem_addr       = req_addr[win];
          mem_wdata      = req_wdata[win];
          issue_tag.vld  = ~req_we[win];
          issue_tag.id   = win;
          issue_tag.last = (req_len[win] == '0);
          if (req_len[win] != '0) begin
            // Pointer stays put until the burst closes.
            state_d = S_BURST;
            owner_d = win;
            base_d  = req_addr[win];
            we_d    = req_we[win];
            len_d   = req_len[win];
            beat_d  = BURST_W'(1);
          end else begin
            ptr_d = next_id(win);
          end
        end
      end
      S_BURST: begin
        // Owner without valid simply stalls the burst; nobody else is served.
        if (req_valid[owner_q]) begin
          req_ready[owner_q] = 1'b1;
          mem_en             = 1'b1;
          mem_we             = we_q;
          mem_addr           = base_q + ADDR_W'(beat_q);
          mem_wdata          = req_wdata[owner_q];
          issue_tag.vld      = ~we_q;
          issue_tag.id       = owner_q;
          issue_tag.last     = (beat_q == len_q);
          if (beat_q == len_q) begin
            state_d = S_IDLE;
            ptr_d   = next_id(owner_q);
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`else
    if (found) begin
      req_ready[win] = 1'b1;
      mem_en         = 1'b1;
      mem_we         = req_we[win];
      mem_addr       = req_addr[win];
      mem_wdata      = req_wdata[win];
      issue_tag.vld  = ~req_we[win];
      issue_tag.id   = win;
      issue_tag.last = 1'b1;
      ptr_d          = next_id(win);
    end
`endif
    // Tag pipeline mirrors the SRAM read latency; stage RD_LAT lines up with mem_rdata.
    tag_d[1] = issue_tag;
    for (int s = 2; s <= RD_LAT; s++) tag_d[s] = tag_q[s-1];

    rsp_valid = tag_q[RD_LAT].vld ? (NUM_REQS'(1) << tag_q[RD_LAT].id) : '0;
    rsp_data  = tag_q[RD_LAT].vld ? mem_rdata : '0;
    rsp_last  = tag_q[RD_LAT].vld & tag_q[RD_LAT].last;
    busy      = 1'b0;
    for (int s = 1; s <= RD_LAT; s++) busy = busy | tag_q[s].vld;
`ifdef MEM_SCHED_BURST_LOCK_EN
    busy = busy | (state_q == S_BURST);
`endif

    // Outputs are forced quiet while reset is held, whatever the inputs do.
    if (reset) begin
      req_ready = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rsp_valid = '0;
      rsp_data  = '0;
      rsp_last  = 1'b0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      tag_q   <= '0;
`ifdef MEM_SCHED_BURST_LOCK_EN
      state_q <= S_IDLE;
      owner_q <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      len_q   <= '0;
      beat_q  <= '0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
`ifdef MEM_SCHED_BURST_LOCK_EN
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      we_q    <= we_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_port_scheduler.sv
module tb_mem_port_scheduler;
  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 3;
  localparam int RL = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NR-1:0]        req_valid, req_ready, req_we;
  logic [NR-1:0][AW-1:0] req_addr;
  logic [NR-1:0][BW-1:0] req_len;
  logic [NR-1:0][DW-1:0] req_wdata;
  logic                 mem_en, mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata, mem_rdata;
  logic [NR-1:0]        rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic                 rsp_last, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  mem_port_scheduler #(.NUM_REQS(NR), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .RD_LAT(RL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return 32'hA500_0000 | DW'(a);
  endfunction

  // SRAM model: unwritten words read back as a fixed address pattern.
  logic [DW-1:0]        sram [0:(1<<AW)-1];
  logic [(1<<AW)-1:0]   written = '0;
  logic [DW-1:0]        rd_pipe [0:RL-1];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      sram[mem_addr]    <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    rd_pipe[0] <= written[mem_addr] ? sram[mem_addr] : pat(mem_addr);
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RL-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [BW-1:0] len, input logic [DW-1:0] wd);
    req_we[i]    = we;
    req_addr[i]  = a;
    req_len[i]   = len;
    req_wdata[i] = wd;
  endtask

  task automatic exp_rsp(input int id, input logic [DW-1:0] d, input logic last);
    exp_t e;
    e.id   = id;
    e.data = d;
    e.last = last;
    e.cyc  = cyc + RL;
    sb.push_back(e);
  endtask

  task automatic expect_issue(input string tag, input logic [NR-1:0] rdy, input logic en,
                              input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    @(negedge clk);
    chk({tag, "/ready"}, req_ready, rdy);
    chk({tag, "/mem_en"}, mem_en, en);
    if (en) begin
      chk({tag, "/mem_we"}, mem_we, we);
      chk({tag, "/mem_addr"}, mem_addr, a);
      if (we) chk({tag, "/mem_wdata"}, mem_wdata, wd);
    end
  endtask

  // Response monitor: pops the scoreboard on every response and flags late ones.
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        mon_e = sb.pop_front();
        chk("rsp_valid", rsp_valid, NR'(1) << mon_e.id);
        chk("rsp_data", rsp_data, mon_e.data);
        chk("rsp_last", rsp_last, mon_e.last);
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      chk("rsp_missing", rsp_valid, NR'(1) << sb[0].id);
      void'(sb.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(16 + i), '0, '0);
    req_valid = '1;

    // Reset holds every output quiet even with all requests asserted.
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
    end
    #1 reset = 1'b0;

    // Round robin over four single-beat reads, wrapping back to req0.
    for (int k = 0; k < 5; k++) begin
      exp_rsp(k % NR, pat(AW'(16 + k % NR)), 1'b1);
      expect_issue("rr", NR'(1 << (k % NR)), 1'b1, 1'b0, AW'(16 + k % NR), '0);
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    chk("busy_inflight", busy, 1);
    chk("idle_mem_en", mem_en, 0);
    chk("idle_ready", req_ready, 0);
    tick(); tick();
    @(negedge clk);
    chk("busy_drained", busy, 0);
    tick();

`ifdef MEM_SCHED_BURST_LOCK_EN
    // ptr=1: req1 4-beat write wrapping past 0x3FF; req2 waits, req1 fields change mid-burst.
    set_req(1, 1'b1, 10'h3FE, 3'd3, 32'hD0D0_0000);
    set_req(2, 1'b0, 10'h020, 3'd0, '0);
    req_valid = 4'b0110;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin req_addr[1] = 10'h155; req_we[1] = 1'b0; req_len[1] = '0; end
      req_wdata[1] = 32'hD0D0_0000 + DW'(b);
      expect_issue("burst_wr", 4'b0010, 1'b1, 1'b1, AW'(10'h3FE + b), 32'hD0D0_0000 + DW'(b));
      tick();
    end
    exp_rsp(2, pat(10'h020), 1'b1);
    expect_issue("burst_then_req2", 4'b0100, 1'b1, 1'b0, 10'h020, '0);
    tick();
    req_valid = '0;

    // ptr=3: read back the wrapped words.
    set_req(3, 1'b0, 10'h3FF, 3'd1, '0);
    req_valid = 4'b1000;
    exp_rsp(3, 32'hD0D0_0001, 1'b0);
    expect_issue("readback_b0", 4'b1000, 1'b1, 1'b0, 10'h3FF, '0);
    tick();
    exp_rsp(3, 32'hD0D0_0002, 1'b1);
    expect_issue("readback_b1", 4'b1000, 1'b1, 1'b0, 10'h000, '0);
    tick();
    req_valid = '0;

    // ptr=0: owner stalls two cycles mid-burst while req1 keeps asking.
    set_req(0, 1'b0, 10'h040, 3'd3, '0);
    set_req(1, 1'b0, 10'h050, 3'd0, '0);
    req_valid = 4'b0011;
    for (int b = 0; b < 2; b++) begin
      exp_rsp(0, pat(AW'(10'h040 + b)), 1'b0);
      expect_issue("stall_pre", 4'b0001, 1'b1, 1'b0, AW'(10'h040 + b), '0);
      tick();
    end
    req_valid[0] = 1'b0;
    repeat (2) begin
      expect_issue("stall_gap", 4'b0000, 1'b0, 1'b0, '0, '0);
      tick();
    end
    req_valid[0] = 1'b1;
    for (int b = 2; b < 4; b++) begin
      exp_rsp(0, pat(AW'(10'h040 + b)), b == 3);
      expect_issue("stall_post", 4'b0001, 1'b1, 1'b0, AW'(10'h040 + b), '0);
      tick();
    end
    exp_rsp(1, pat(10'h050), 1'b1);
    expect_issue("stall_then_req1", 4'b0010, 1'b1, 1'b0, 10'h050, '0);
    tick();
    req_valid = '0;

    // ptr=2: req3 two-beat read.
    set_req(3, 1'b0, 10'h060, 3'd1, '0);
    req_valid = 4'b1000;
    exp_rsp(3, pat(10'h060), 1'b0);
    expect_issue("req3_b0", 4'b1000, 1'b1, 1'b0, 10'h060, '0);
    tick();
    exp_rsp(3, pat(10'h061), 1'b1);
    expect_issue("req3_b1", 4'b1000, 1'b1, 1'b0, 10'h061, '0);
    chk("burst_busy", busy, 1);
    tick();
    req_valid = '0;

    // ptr=0: one read by req0 moves ptr to 1 before the burst that gets reset.
    set_req(0, 1'b0, 10'h008, 3'd0, '0);
    req_valid = 4'b0001;
    exp_rsp(0, pat(10'h008), 1'b1);
    expect_issue("pre_rst_req0", 4'b0001, 1'b1, 1'b0, 10'h008, '0);
    tick();
    set_req(2, 1'b0, 10'h070, 3'd3, '0);
    req_valid = 4'b0100;
    expect_issue("drop_b0", 4'b0100, 1'b1, 1'b0, 10'h070, '0);
    tick();
    expect_issue("drop_b1", 4'b0100, 1'b1, 1'b0, 10'h071, '0);
    tick();
`else
    // ptr=1: req_len ignored, req1 writes and req2 reads interleave beat by beat.
    set_req(1, 1'b1, 10'h3FE, 3'd3, 32'hD0D0_0000);
    set_req(2, 1'b0, 10'h020, 3'd3, '0);
    req_valid = 4'b0110;
    expect_issue("nl_wr0", 4'b0010, 1'b1, 1'b1, 10'h3FE, 32'hD0D0_0000);
    tick();
    req_addr[1] = 10'h3FF; req_wdata[1] = 32'hD0D0_0001;
    exp_rsp(2, pat(10'h020), 1'b1);
    expect_issue("nl_rd0", 4'b0100, 1'b1, 1'b0, 10'h020, '0);
    tick();
    expect_issue("nl_wr1", 4'b0010, 1'b1, 1'b1, 10'h3FF, 32'hD0D0_0001);
    tick();
    req_valid[1] = 1'b0;
    exp_rsp(2, pat(10'h020), 1'b1);
    expect_issue("nl_rd1", 4'b0100, 1'b1, 1'b0, 10'h020, '0);
    tick();
    req_valid = '0;

    // ptr=3: read back, req3 and req0 alternate.
    set_req(3, 1'b0, 10'h3FE, 3'd2, '0);
    set_req(0, 1'b0, 10'h3FF, 3'd5, '0);
    req_valid = 4'b1001;
    exp_rsp(3, 32'hD0D0_0000, 1'b1);
    expect_issue("nl_rb3a", 4'b1000, 1'b1, 1'b0, 10'h3FE, '0);
    tick();
    exp_rsp(0, 32'hD0D0_0001, 1'b1);
    expect_issue("nl_rb0", 4'b0001, 1'b1, 1'b0, 10'h3FF, '0);
    tick();
    exp_rsp(3, 32'hD0D0_0000, 1'b1);
    expect_issue("nl_rb3b", 4'b1000, 1'b1, 1'b0, 10'h3FE, '0);
    tick();
    req_valid = '0;

    // ptr=0: scan skips idle requesters.
    set_req(2, 1'b0, 10'h030, '0, '0);
    set_req(3, 1'b0, 10'h031, '0, '0);
    req_valid = 4'b1100;
    exp_rsp(2, pat(10'h030), 1'b1);
    expect_issue("nl_skip2a", 4'b0100, 1'b1, 1'b0, 10'h030, '0);
    tick();
    exp_rsp(3, pat(10'h031), 1'b1);
    expect_issue("nl_skip3", 4'b1000, 1'b1, 1'b0, 10'h031, '0);
    tick();
    exp_rsp(2, pat(10'h030), 1'b1);
    expect_issue("nl_skip2b", 4'b0100, 1'b1, 1'b0, 10'h030, '0);
    tick();
    req_valid = '0;

    // ptr=3: two reads by req2 that reset will drop.
    set_req(2, 1'b0, 10'h070, '0, '0);
    req_valid = 4'b0100;
    expect_issue("drop_b0", 4'b0100, 1'b1, 1'b0, 10'h070, '0);
    tick();
    expect_issue("drop_b1", 4'b0100, 1'b1, 1'b0, 10'h070, '0);
    tick();
`endif

    // Reset with reads in flight: nothing returns, then req0 wins the 0/2 tie.
    reset = 1'b1;
    set_req(0, 1'b0, 10'h080, '0, '0);
    set_req(2, 1'b0, 10'h090, '0, '0);
    req_valid = 4'b0101;
    repeat (2) begin
      @(negedge clk);
      chk("rst2_ready", req_ready, 0);
      chk("rst2_mem_en", mem_en, 0);
      chk("rst2_rsp_valid", rsp_valid, 0);
      chk("rst2_busy", busy, 0);
      tick();
    end
    reset = 1'b0;
    exp_rsp(0, pat(10'h080), 1'b1);
    expect_issue("post_rst_tie", 4'b0001, 1'b1, 1'b0, 10'h080, '0);
    tick();
    exp_rsp(2, pat(10'h090), 1'b1);
    expect_issue("post_rst_next", 4'b0100, 1'b1, 1'b0, 10'h090, '0);
    tick();
    req_valid = '0;

    repeat (4) tick();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
